instr_fetch_decode: RTL and testbench

- Feeds the PC controller of the Simple Computer.
- Fetches the instruction at the current PC from instruction memory over a req/valid handshake and holds it in an instruction register (IR).
- Decodes the IR into the datapath control word, including PL, JB, BC, branch_offset and jump-source selects.
- Gates all state-changing strobes (RW, MW, PL, pc_en) so each instruction takes effect in exactly one execute cycle.

---
 rtl/instr_fetch_decode_pkg.sv | 54 +++++
 rtl/instr_fetch_decode_instr_decoder.sv | 89 ++++++++
 rtl/instr_fetch_decode.sv | 123 ++++++++++++
 tb/tb_instr_fetch_decode.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the Simple Computer fetch/decode stage: opcodes,
// function-unit selects, FSM state encoding and control-word field widths.
package instr_fetch_decode_pkg;

    localparam int OPC_W = 7;
    localparam int REG_W = 3;
    localparam int FS_W  = 4;
    localparam int OFF_W = 6;
    localparam int CNT_W = 4;

    // Register-to-register operations (FS is the low four opcode bits)
    localparam logic [OPC_W-1:0] OP_MOVA = 7'b0000000;
    localparam logic [OPC_W-1:0] OP_INC  = 7'b0000001;
    localparam logic [OPC_W-1:0] OP_ADD  = 7'b0000010;
    localparam logic [OPC_W-1:0] OP_SUB  = 7'b0000101;
    localparam logic [OPC_W-1:0] OP_DEC  = 7'b0000110;
    localparam logic [OPC_W-1:0] OP_AND  = 7'b0001000;
    localparam logic [OPC_W-1:0] OP_OR   = 7'b0001001;
    localparam logic [OPC_W-1:0] OP_XOR  = 7'b0001010;
    localparam logic [OPC_W-1:0] OP_NOT  = 7'b0001011;
    localparam logic [OPC_W-1:0] OP_MOVB = 7'b0001100;
    localparam logic [OPC_W-1:0] OP_SHR  = 7'b0001101;
    localparam logic [OPC_W-1:0] OP_SHL  = 7'b0001110;

    // Memory, immediate and control-flow operations
    localparam logic [OPC_W-1:0] OP_LD   = 7'b0010000;
    localparam logic [OPC_W-1:0] OP_ST   = 7'b0100000;
    localparam logic [OPC_W-1:0] OP_LDI  = 7'b1001100;
    localparam logic [OPC_W-1:0] OP_ADI  = 7'b1000010;
    localparam logic [OPC_W-1:0] OP_BRZ  = 7'b1100000;
    localparam logic [OPC_W-1:0] OP_BRN  = 7'b1100001;
    localparam logic [OPC_W-1:0] OP_JMP  = 7'b1110000;

    localparam logic [FS_W-1:0] FS_ZERO = 4'b0000;
    localparam logic [FS_W-1:0] FS_ADD  = 4'b0010;
    localparam logic [FS_W-1:0] FS_MOVB = 4'b1100;

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_FETCH      = 3'd1,
        S_WAIT       = 3'd2,
        S_EXEC       = 3'd3,
        S_HALT       = 3'd4
    } state_t;

    function automatic logic is_reg_op(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND,
            OP_OR, OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_decode_instr_decoder.sv
// Combinational IR-to-control-word decoder. Strobes come out ungated;
// the fetch FSM qualifies them with the execute state.
module instr_decoder
    import instr_fetch_decode_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0]    ir,
    output logic [REG_W-1:0] da,
    output logic [REG_W-1:0] aa,
    output logic [REG_W-1:0] ba,
    output logic             mb,
    output logic [FS_W-1:0]  fs,
    output logic             md,
    output logic             rw,
    output logic             mw,
    output logic             pl,
    output logic             jb,
    output logic             bc,
    output logic [IW-1:0]    branch_offset,
    output logic [IW-1:0]    const_out,
    output logic             legal
);

    logic [OPC_W-1:0] opcode;
    logic [OFF_W-1:0] off6;

    assign opcode = ir[IW-1:IW-OPC_W];
    assign da     = ir[8:6];
    assign aa     = ir[5:3];
    assign ba     = ir[2:0];

    // The branch offset borrows the DR and SB fields: {IR[8:6], IR[2:0]}
    assign off6          = {ir[8:6], ir[2:0]};
    assign branch_offset = {{(IW-OFF_W){off6[OFF_W-1]}}, off6};
    assign const_out     = {{(IW-REG_W){1'b0}}, ir[2:0]};

    always_comb begin
        mb    = 1'b0;
        fs    = FS_ZERO;
        md    = 1'b0;
        rw    = 1'b0;
        mw    = 1'b0;
        pl    = 1'b0;
        jb    = 1'b0;
        bc    = 1'b0;
        legal = 1'b1;
        if (is_reg_op(opcode)) begin
            fs = opcode[FS_W-1:0];
            rw = 1'b1;
        end else begin
            case (opcode)
                OP_LD: begin
                    md = 1'b1;
                    rw = 1'b1;
                end
                OP_ST: begin
                    mw = 1'b1;
                end
                OP_LDI: begin
                    mb = 1'b1;
                    fs = FS_MOVB;
                    rw = 1'b1;
                end
                OP_ADI: begin
                    mb = 1'b1;
                    fs = FS_ADD;
                    rw = 1'b1;
                end
                OP_BRZ: begin
                    pl = 1'b1;
                end
                OP_BRN: begin
                    pl = 1'b1;
                    bc = 1'b1;
                end
                OP_JMP: begin
                    pl = 1'b1;
                    jb = 1'b1;
                end
                default: begin
                    // Undecodable opcode runs as a NOP
                    legal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode for the Simple Computer: fetches at pc,
// holds the word in IR and drives a control word strobed for one EXEC cycle.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int IW       = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IW-1:0]    pc,
    output logic             imem_req,
    output logic [IW-1:0]    imem_addr,
    input  logic             imem_valid,
    input  logic [IW-1:0]    imem_data,
    output logic             pc_en,
    output logic [REG_W-1:0] DA,
    output logic [REG_W-1:0] AA,
    output logic [REG_W-1:0] BA,
    output logic             MB,
    output logic [FS_W-1:0]  FS,
    output logic             MD,
    output logic             RW,
    output logic             MW,
    output logic             PL,
    output logic             JB,
    output logic             BC,
    output logic [IW-1:0]    branch_offset,
    output logic [IW-1:0]    const_out,
    output logic             illegal,
    output logic             fault,
    output logic [2:0]       fsm_state
);

    // Handshake: imem_req rises in FETCH and stays high with imem_addr frozen
    // until imem_valid is seen in WAIT; imem_valid anywhere else is ignored.
    state_t           state;
    logic [IW-1:0]    ir;
    logic [IW-1:0]    addr_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_exec;
    logic             dec_rw;
    logic             dec_mw;
    logic             dec_pl;
    logic             dec_legal;

    instr_decoder #(.IW(IW)) u_decoder (
        .ir            (ir),
        .da            (DA),
        .aa            (AA),
        .ba            (BA),
        .mb            (MB),
        .fs            (FS),
        .md            (MD),
        .rw            (dec_rw),
        .mw            (dec_mw),
        .pl            (dec_pl),
        .jb            (JB),
        .bc            (BC),
        .branch_offset (branch_offset),
        .const_out     (const_out),
        .legal         (dec_legal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_RESET_HOLD;
            ir       <= '0;
            addr_q   <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    addr_q   <= pc;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        ir    <= imem_data;
                        state <= S_EXEC;
                    end else begin
                        if (wait_cnt != {CNT_W{1'b1}}) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        // wait_cnt counts completed WAIT cycles, so this is the last allowed one
                        if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                            fault <= 1'b1;
                            state <= S_HALT;
                        end
                    end
                end
                S_EXEC: begin
                    if (!dec_legal) begin
                        illegal <= 1'b1;
                    end
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    assign in_exec   = (state == S_EXEC);
    assign imem_req  = (state == S_FETCH) || (state == S_WAIT);
    assign imem_addr = (state == S_FETCH) ? pc : addr_q;
    assign pc_en     = in_exec;
    assign RW        = dec_rw & in_exec;
    assign MW        = dec_mw & in_exec;
    assign PL        = dec_pl & in_exec;
    assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: drives the imem handshake, queues the
// expected control word when data is delivered and checks it in EXEC.
module tb_instr_fetch_decode;

    localparam logic [2:0] ST_RESET_HOLD = 3'd0;
    localparam logic [2:0] ST_FETCH      = 3'd1;
    localparam logic [2:0] ST_WAIT       = 3'd2;
    localparam logic [2:0] ST_EXEC       = 3'd3;
    localparam logic [2:0] ST_HALT       = 3'd4;
    localparam int CW = 52;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        pc_en;
    logic [2:0]  DA, AA, BA;
    logic        MB;
    logic [3:0]  FS;
    logic        MD, RW, MW, PL, JB, BC;
    logic [15:0] branch_offset;
    logic [15:0] const_out;
    logic        illegal;
    logic        fault;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] obs_cw;
    logic [3:0]    strobes;

    assign obs_cw  = {DA, AA, BA, MB, FS, MD, RW, MW, PL, JB, BC, branch_offset, const_out};
    assign strobes = {pc_en, RW, MW, PL};

    always #5 clock = ~clock;

    instr_fetch_decode #(.IW(16), .MAX_WAIT(15)) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_data     (imem_data),
        .pc_en         (pc_en),
        .DA            (DA),
        .AA            (AA),
        .BA            (BA),
        .MB            (MB),
        .FS            (FS),
        .MD            (MD),
        .RW            (RW),
        .MW            (MW),
        .PL            (PL),
        .JB            (JB),
        .BC            (BC),
        .branch_offset (branch_offset),
        .const_out     (const_out),
        .illegal       (illegal),
        .fault         (fault),
        .fsm_state     (fsm_state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk_cw(
        input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
        input logic mb, input logic [3:0] fs, input logic md, input logic rw,
        input logic mw, input logic pl, input logic jb, input logic bc,
        input logic [15:0] off, input logic [15:0] cst);
        return {da, aa, ba, mb, fs, md, rw, mw, pl, jb, bc, off, cst};
    endfunction

    // Entered in a FETCH cycle, returns in the following FETCH cycle.
    task automatic do_instr(input string tag, input logic [15:0] pc_val, input logic [15:0] instr,
                            input int extra_wait, input logic junk, input logic [CW-1:0] exp_cw);
        pc = pc_val;
        #1;
        chk({tag, " fetch_state"}, 64'(fsm_state), 64'(ST_FETCH));
        chk({tag, " fetch_req"}, 64'(imem_req), 64'd1);
        chk({tag, " fetch_addr"}, 64'(imem_addr), 64'(pc_val));
        chk({tag, " fetch_strobes"}, 64'(strobes), 64'd0);
        if (junk) begin
            imem_valid = 1'b1;
            imem_data  = ~instr;
        end
        tick();
        for (int w = 0; w <= extra_wait; w++) begin
            imem_valid = 1'b0;
            pc = 16'($urandom_range(0, 65535));
            #1;
            chk({tag, " wait_state"}, 64'(fsm_state), 64'(ST_WAIT));
            chk({tag, " wait_req"}, 64'(imem_req), 64'd1);
            chk({tag, " wait_addr"}, 64'(imem_addr), 64'(pc_val));
            chk({tag, " wait_strobes"}, 64'(strobes), 64'd0);
            if (w == extra_wait) begin
                imem_valid = 1'b1;
                imem_data  = instr;
                exp_q.push_back(exp_cw);
            end
            tick();
        end
        imem_valid = 1'b0;
        imem_data  = 16'($urandom_range(0, 65535));
        chk({tag, " exec_state"}, 64'(fsm_state), 64'(ST_EXEC));
        chk({tag, " exec_pc_en"}, 64'(pc_en), 64'd1);
        if (exp_q.size() != 0) begin
            chk({tag, " exec_cw"}, 64'(obs_cw), 64'(exp_q.pop_front()));
        end else begin
            n_checks++;
            n_fail++;
            $error("FAIL %s exec_cw: observed %0h expected queued entry", tag, obs_cw);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        // RESET_HOLD: everything quiet; a stray valid here must be ignored
        chk("reset_state", 64'(fsm_state), 64'(ST_RESET_HOLD));
        chk("reset_outputs", 64'({imem_req, imem_addr, obs_cw[51:32]}), 64'd0);
        chk("reset_outputs_lo", 64'({obs_cw[31:0], pc_en, illegal, fault}), 64'd0);
        imem_valid = 1'b1;
        imem_data  = 16'hFFFF;
        tick();
        imem_valid = 1'b0;
        chk("hold_valid_ignored", 64'(obs_cw), 64'd0);

        do_instr("add", 16'h0010, 16'h0453, 0, 1'b0,
                 mk_cw(3'd1, 3'd2, 3'd3, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000B, 16'h0003));
        chk("add_no_illegal", 64'(illegal), 64'd0);
        do_instr("brz", 16'h0011, 16'hC1C6, 0, 1'b0,
                 mk_cw(3'd7, 3'd0, 3'd6, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0006));
        chk("brz_pl_after", 64'(PL), 64'd0);
        do_instr("jmp", 16'h000F, 16'hE028, 0, 1'b0,
                 mk_cw(3'd0, 3'd5, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000));
        do_instr("ld_wait5", 16'h0020, 16'h20E0, 5, 1'b0,
                 mk_cw(3'd3, 3'd4, 3'd0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0018, 16'h0000));
        do_instr("st", 16'h0021, 16'h4011, 1, 1'b0,
                 mk_cw(3'd0, 3'd2, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001));
        do_instr("ldi", 16'h0022, 16'h9885, 0, 1'b0,
                 mk_cw(3'd2, 3'd0, 3'd5, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0015, 16'h0005));
        do_instr("adi", 16'h0023, 16'h844F, 2, 1'b0,
                 mk_cw(3'd1, 3'd1, 3'd7, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000F, 16'h0007));
        do_instr("brn", 16'h0024, 16'hC301, 0, 1'b0,
                 mk_cw(3'd4, 3'd0, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFE1, 16'h0001));
        chk("legal_no_illegal", 64'(illegal), 64'd0);

        do_instr("illegal_ff", 16'h0030, 16'hFE00, 0, 1'b0, '0);
        chk("illegal_set", 64'(illegal), 64'd1);
        do_instr("sub_junk_fetch", 16'h0031, 16'h0A49, 0, 1'b1,
                 mk_cw(3'd1, 3'd1, 3'd1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0009, 16'h0001));
        chk("illegal_sticky", 64'(illegal), 64'd1);
        do_instr("illegal_03", 16'h0032, 16'h0600, 0, 1'b0, '0);
        chk("illegal_still", 64'(illegal), 64'd1);

        // Reset in the middle of a fetch handshake, late valid afterwards
        pc = 16'h0040;
        #1;
        tick();
        chk("midreset_wait", 64'(fsm_state), 64'(ST_WAIT));
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 16'h0453;
        #1;
        chk("midreset_hold", 64'(fsm_state), 64'(ST_RESET_HOLD));
        chk("midreset_req", 64'(imem_req), 64'd0);
        chk("midreset_ir", 64'(obs_cw), 64'd0);
        chk("midreset_illegal", 64'(illegal), 64'd0);
        tick();
        imem_valid = 1'b0;
        chk("midreset_fetch", 64'(fsm_state), 64'(ST_FETCH));
        chk("midreset_ir_fetch", 64'(obs_cw), 64'd0);
        do_instr("after_reset", 16'h0050, 16'h0453, 0, 1'b0,
                 mk_cw(3'd1, 3'd2, 3'd3, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000B, 16'h0003));

        // Fetch timeout: memory never answers
        pc = 16'h0100;
        #1;
        tick();
        for (int w = 0; w < 15; w++) begin
            chk("timeout_wait_state", 64'(fsm_state), 64'(ST_WAIT));
            chk("timeout_wait_req", 64'(imem_req), 64'd1);
            chk("timeout_wait_fault", 64'(fault), 64'd0);
            tick();
        end
        chk("timeout_halt", 64'(fsm_state), 64'(ST_HALT));
        chk("timeout_fault", 64'(fault), 64'd1);
        chk("timeout_req", 64'(imem_req), 64'd0);
        chk("timeout_strobes", 64'(strobes), 64'd0);
        imem_valid = 1'b1;
        imem_data  = 16'h0453;
        tick();
        imem_valid = 1'b0;
        tick();
        chk("halt_stays", 64'(fsm_state), 64'(ST_HALT));
        chk("halt_fault_stays", 64'(fault), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("fault_cleared", 64'(fault), 64'd0);
        chk("fault_reset_state", 64'(fsm_state), 64'(ST_RESET_HOLD));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
